// File: rtl/line_raster_stage.sv
// Pairs rounded Q-format vertices into segments and walks them with integer Bresenham, clipping to the screen.
// Optional build macro LINE_STRIP_EN: adds strip_break and chains segments end-to-start.
module line_raster_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int SCREEN_W    = 128,
  parameter int SCREEN_H    = 128,
  parameter int COORD_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [DATA_WIDTH-1:0] pt_x,
  input  logic [DATA_WIDTH-1:0] pt_y,
`ifdef LINE_STRIP_EN
  input  logic                  strip_break,
`endif
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [COORD_WIDTH-1:0] pix_x,
  output logic [COORD_WIDTH-1:0] pix_y,
  output logic                  busy,
  output logic                  line_done
);

  localparam int IW = DATA_WIDTH - FRAC_BITS + 1;
  localparam int EW = IW + 3;
  typedef logic signed [EW-1:0] coord_t;

  typedef enum logic [2:0] {IDLE, WAIT_P1, SETUP, DRAW, DONE} state_t;

  state_t state_q, state_d;
  coord_t x0_q, y0_q, x1_q, y1_q, cx_q, cy_q, dx_q, dy_q, err_q, sx_q, sy_q;
  coord_t x0_d, y0_d, x1_d, y1_d, cx_d, cy_d, dx_d, dy_d, err_d, sx_d, sy_d;

  // Round half up, then widen so segment deltas and doubled error never overflow.
  function automatic coord_t round_q(input logic [DATA_WIDTH-1:0] v);
    logic signed [DATA_WIDTH:0] t;
    t = $signed({v[DATA_WIDTH-1], v}) + $signed((DATA_WIDTH+1)'(1 << (FRAC_BITS-1)));
    return {{(EW-IW){t[DATA_WIDTH]}}, t[DATA_WIDTH:FRAC_BITS]};
  endfunction

  function automatic coord_t sign_of(input coord_t d);
    if (d > 0)      return coord_t'(1);
    else if (d < 0) return coord_t'(-1);
    else            return coord_t'(0);
  endfunction

  function automatic coord_t abs_of(input coord_t d);
    return (d < 0) ? -d : d;
  endfunction

  coord_t                ddx, ddy, adx, ady, err_nx;
  logic signed [EW:0]    e2;
  logic                  in_bounds, xfer, advance, at_end;

  assign ddx       = x1_q - x0_q;
  assign ddy       = y1_q - y0_q;
  assign adx       = abs_of(ddx);
  assign ady       = abs_of(ddy);
  assign e2        = $signed({err_q, 1'b0});
  assign in_bounds = (cx_q >= 0) && (cx_q < coord_t'(SCREEN_W)) &&
                     (cy_q >= 0) && (cy_q < coord_t'(SCREEN_H));
  assign xfer      = pt_valid && pt_ready;
  assign advance   = !in_bounds || pix_ready;
  assign at_end    = (cx_q == x1_q) && (cy_q == y1_q);

  assign pt_ready  = (state_q == IDLE) || (state_q == WAIT_P1);
  assign busy      = (state_q == SETUP) || (state_q == DRAW);
  assign line_done = (state_q == DONE);
  assign pix_valid = (state_q == DRAW) && in_bounds;
  assign pix_x     = pix_valid ? cx_q[COORD_WIDTH-1:0] : '0;
  assign pix_y     = pix_valid ? cy_q[COORD_WIDTH-1:0] : '0;

  always_comb begin
    state_d = state_q;
    x0_d = x0_q;  y0_d = y0_q;  x1_d = x1_q;  y1_d = y1_q;
    cx_d = cx_q;  cy_d = cy_q;  dx_d = dx_q;  dy_d = dy_q;
    sx_d = sx_q;  sy_d = sy_q;  err_d = err_q;
    err_nx = err_q;
    unique case (state_q)
      IDLE: if (xfer) begin
        x0_d    = round_q(pt_x);
        y0_d    = round_q(pt_y);
        state_d = WAIT_P1;
      end
      WAIT_P1: if (xfer) begin
`ifdef LINE_STRIP_EN
        if (strip_break) begin
          x0_d = round_q(pt_x);
          y0_d = round_q(pt_y);
        end else begin
          x1_d    = round_q(pt_x);
          y1_d    = round_q(pt_y);
          state_d = SETUP;
        end
`else
        x1_d    = round_q(pt_x);
        y1_d    = round_q(pt_y);
        state_d = SETUP;
`endif
      end
      SETUP: begin
        dx_d    = adx;
        dy_d    = -ady;
        sx_d    = sign_of(ddx);
        sy_d    = sign_of(ddy);
        err_d   = adx - ady;
        cx_d    = x0_q;
        cy_d    = y0_q;
        state_d = DRAW;
      end
      DRAW: if (advance) begin
        if (at_end) begin
          state_d = DONE;
        end else begin
          // Both axis decisions use the error from before this step.
          if (e2 >= dy_q) begin
            err_nx = err_nx + dy_q;
            cx_d   = cx_q + sx_q;
          end
          if (e2 <= dx_q) begin
            err_nx = err_nx + dx_q;
            cy_d   = cy_q + sy_q;
          end
          err_d = err_nx;
        end
      end
      DONE: begin
`ifdef LINE_STRIP_EN
        x0_d    = x1_q;
        y0_d    = y1_q;
        state_d = WAIT_P1;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    x0_q  <= x0_d;  y0_q <= y0_d;  x1_q <= x1_d;  y1_q <= y1_d;
    cx_q  <= cx_d;  cy_q <= cy_d;  dx_q <= dx_d;  dy_q <= dy_d;
    sx_q  <= sx_d;  sy_q <= sy_d;  err_q <= err_d;
  end

endmodule

// File: tb/tb_line_raster_stage.sv
// Scoreboard bench for line_raster_stage: directed segments plus randomized vertices against a plain-integer line model.
module tb_line_raster_stage;
  localparam int DW = 16, FB = 8, SW = 128, SH = 128, CW = 7;

  logic          clk = 1'b0, rst = 1'b1;
  logic          pt_valid = 1'b0, pix_ready = 1'b0;
  logic [DW-1:0] pt_x = '0, pt_y = '0;
  logic          pt_ready, pix_valid, busy, line_done;
  logic [CW-1:0] pix_x, pix_y;
`ifdef LINE_STRIP_EN
  logic          strip_break = 1'b0;
`endif

  line_raster_stage #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .SCREEN_W(SW), .SCREEN_H(SH),
                      .COORD_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y),
`ifdef LINE_STRIP_EN
    .strip_break(strip_break),
`endif
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .line_done(line_done));

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit done; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  bit   mon_en = 1'b0;
  int   rdy_mode = 0;
  bit   have_p0 = 1'b0;
  int   m0x = 0, m0y = 0;

  function automatic void chk(string name, bit ok, int act, int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endfunction

  // Nearest integer with ties toward +infinity.
  function automatic int to_pix(logic [DW-1:0] v);
    real r;
    r = real'(int'($signed(v))) / real'(1 << FB);
    return int'($floor(r + 0.5));
  endfunction

  function automatic void model_draw(int x0, int y0, int x1, int y1);
    int x, y, dx, dy, sx, sy, err, e2;
    exp_t e;
    x = x0; y = y0;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x1 > x0) ? 1 : ((x1 < x0) ? -1 : 0);
    sy = (y1 > y0) ? 1 : ((y1 < y0) ? -1 : 0);
    err = dx + dy;
    for (int i = 0; i < 4000; i++) begin
      if (x >= 0 && x < SW && y >= 0 && y < SH) begin
        e.x = x; e.y = y; e.done = 1'b0;
        sb.push_back(e);
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    e.x = 0; e.y = 0; e.done = 1'b1;
    sb.push_back(e);
  endfunction

  function automatic void model_vertex(logic [DW-1:0] vx, logic [DW-1:0] vy);
    int rx, ry;
    rx = to_pix(vx); ry = to_pix(vy);
    if (!have_p0) begin
      m0x = rx; m0y = ry; have_p0 = 1'b1;
    end else begin
      model_draw(m0x, m0y, rx, ry);
`ifdef LINE_STRIP_EN
      m0x = rx; m0y = ry;
`else
      have_p0 = 1'b0;
`endif
    end
  endfunction

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      2:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every pixel handshake and line_done pulse.
  initial begin
    bit   hold;
    int   hx, hy;
    exp_t e;
    hold = 1'b0; hx = 0; hy = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", pix_valid, int'(pix_valid), 1);
          chk("hold_xy", int'(pix_x) == hx && int'(pix_y) == hy,
              int'(pix_x) * 1000 + int'(pix_y), hx * 1000 + hy);
        end
        hold = 1'b0;
        if (pix_valid && pix_ready) begin
          if (sb.size() == 0) chk("unexpected_pixel", 1'b0, int'(pix_x) * 1000 + int'(pix_y), -1);
          else begin
            e = sb.pop_front();
            chk("pixel_before_done", !e.done, int'(e.done), 0);
            chk("pix_xy", int'(pix_x) == e.x && int'(pix_y) == e.y,
                int'(pix_x) * 1000 + int'(pix_y), e.x * 1000 + e.y);
          end
        end else if (pix_valid) begin
          hold = 1'b1; hx = int'(pix_x); hy = int'(pix_y);
        end
        if (line_done) begin
          if (sb.size() == 0) chk("unexpected_line_done", 1'b0, 1, 0);
          else begin
            e = sb.pop_front();
            chk("line_done_order", e.done, int'(e.done), 1);
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int t;
    t = 0;
    pt_x = x; pt_y = y; pt_valid = 1'b1;
    @(negedge clk);
    while (!pt_ready && t < 3000) begin @(negedge clk); t++; end
    if (!pt_ready) chk("pt_ready_timeout", 1'b0, 0, 1);
    else model_vertex(x, y);
    @(posedge clk); #1;
    pt_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !pt_ready || busy) && t < 5000) begin @(negedge clk); t++; end
    chk("drain", sb.size() == 0 && !busy, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rand_coord();
    if ($urandom_range(0, 1) == 1) return DW'($urandom);
    return DW'(int'($urandom_range(0, 134 * 256)) - 8 * 256);
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", !pix_valid, int'(pix_valid), 0);
    chk("rst_busy", !busy, int'(busy), 0);
    chk("rst_line_done", !line_done, int'(line_done), 0);
    chk("rst_pix_xy", pix_x == 0 && pix_y == 0, int'(pix_x) * 1000 + int'(pix_y), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pt_ready", pt_ready, int'(pt_ready), 1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Horizontal run with latency check.
    rdy_mode = 0;
    send(16'h0000, 16'h0000);
    send(16'h0300, 16'h0000);
    @(negedge clk);
    chk("setup_busy", busy && !pix_valid, int'(busy) * 10 + int'(pix_valid), 10);
    @(negedge clk);
    chk("first_pixel_latency", pix_valid && pix_x == 0 && pix_y == 0, int'(pix_valid), 1);
    drain();

    rdy_mode = 1;
    send(16'h0000, 16'h0000);
    send(16'h0200, 16'h0200);
    drain();

    rdy_mode = 0;
    send(16'hFE00, 16'h0100);
    send(16'h0100, 16'h0100);
    drain();

    send(16'h0180, 16'hFF80);
    send(16'h0180, 16'hFF80);
    drain();

    send(16'hF000, 16'hF000);
    send(16'hF100, 16'hF000);
    drain();
    chk("offscreen_pt_ready", pt_ready, int'(pt_ready), 1);

    // Reset while a pixel is stalled.
    rdy_mode = 3;
    send(16'h0000, 16'h0000);
    send(16'h0500, 16'h0000);
    t = 0;
    while (!pix_valid && t < 100) begin @(negedge clk); t++; end
    chk("stall_pix_valid", pix_valid, int'(pix_valid), 1);
    mon_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_pix_valid", !pix_valid, int'(pix_valid), 0);
    chk("midrst_busy", !busy, int'(busy), 0);
    chk("midrst_pt_ready", pt_ready, int'(pt_ready), 1);
    sb.delete();
    have_p0 = 1'b0;
    mon_en = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    send(16'h0A00, 16'h0A00);
    send(16'h0C00, 16'h0D00);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 80; i++) send(rand_coord(), rand_coord());
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
